// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : int_ctrl
//  Purpose  : N-channel fixed-priority vectored interrupt controller with
//             memory-mapped PENDING / ENABLE / EDGE / STATUS registers.
//  Revision : 1.0 - initial release
// ============================================================================
module int_ctrl #(
    parameter int                N_IRQ         = 8,
    parameter int                DATA_W        = 16,
    parameter logic [DATA_W-1:0] BASE_ADDR     = 16'hFF00,
    parameter logic [DATA_W-1:0] VECTOR_BASE   = 16'h2002,
    parameter int                VECTOR_STRIDE = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ce,
    input  logic [N_IRQ-1:0]  i_irq,
    input  logic [DATA_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_we,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_int,
    output logic [DATA_W-1:0] o_vector,
    input  logic              i_ack,
    input  logic              i_eoi
);

    localparam int C_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_IRQ-1:0]    r_pending;
    logic [N_IRQ-1:0]    r_enable;
    logic [N_IRQ-1:0]    r_edge;
    logic [N_IRQ-1:0]    r_irq_prev;
    logic [C_IDX_W-1:0]  r_active;
    logic [C_IDX_W-1:0]  w_active_nxt;
    logic [DATA_W-1:0]   r_vector;
    logic [DATA_W-1:0]   w_vector_nxt;

    logic [DATA_W-1:0]   w_off;
    logic                w_hit;
    logic                w_wr;
    logic                w_wr_pend;
    logic                w_wr_en;
    logic                w_wr_edge;
    logic [N_IRQ-1:0]    w_wdata_n;
    logic [DATA_W-1:0]   w_status;

    logic [N_IRQ-1:0]    w_req;
    logic                w_found;
    logic [C_IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0]   w_vec_calc;
    logic [N_IRQ-1:0]    w_active_oh;
    logic                w_ack_take;
    logic [N_IRQ-1:0]    w_rise;
    logic [N_IRQ-1:0]    w_clr;
    logic [N_IRQ-1:0]    w_pend_nxt;

    // Write-data bits above N_IRQ are intentionally ignored.
    logic                w_unused_wdata;
    assign w_unused_wdata = &{1'b0, i_wdata};

    // Address decode: the block owns four consecutive words from BASE_ADDR.
    always_comb begin
        w_off     = i_addr - BASE_ADDR;
        w_hit     = (w_off < DATA_W'(4));
        w_wr      = i_ce & i_we & w_hit;
        w_wr_pend = w_wr & (w_off[1:0] == 2'd0);
        w_wr_en   = w_wr & (w_off[1:0] == 2'd1);
        w_wr_edge = w_wr & (w_off[1:0] == 2'd2);
        w_wdata_n = i_wdata[N_IRQ-1:0];
    end

    always_comb begin
        w_status                = '0;
        w_status[C_IDX_W-1:0]   = r_active;
        w_status[15]            = (r_state == ST_SERVICE);
    end

    always_comb begin
        o_rdata = '0;
        if (w_hit) begin
            case (w_off[1:0])
                2'd0:    o_rdata = DATA_W'(r_pending);
                2'd1:    o_rdata = DATA_W'(r_enable);
                2'd2:    o_rdata = DATA_W'(r_edge);
                default: o_rdata = w_status;
            endcase
        end
    end

    // Fixed priority: scan downwards so the lowest set index is left last.
    always_comb begin
        w_req   = r_pending & r_enable;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_found = 1'b1;
                w_idx   = C_IDX_W'(i);
            end
        end
        w_vec_calc = VECTOR_BASE + DATA_W'(int'(w_idx) * VECTOR_STRIDE);
    end

    always_comb begin
        w_active_oh = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            w_active_oh[i] = (r_active == C_IDX_W'(i));
        end
    end

    // Next-state and request/service bookkeeping.
    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_vector_nxt = r_vector;
        w_ack_take   = 1'b0;
        if (i_ce) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        w_active_nxt = w_idx;
                        w_vector_nxt = w_vec_calc;
                        w_state_nxt  = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_ack) begin
                        w_ack_take  = 1'b1;
                        w_state_nxt = ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (i_eoi) begin
                        w_active_nxt = '0;
                        w_state_nxt  = ST_IDLE;
                    end
                end
                default: begin
                    w_active_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end
            endcase
        end
    end

    // Edge channels latch rises and clear on W1C/ack (a new rise wins);
    // level channels simply follow the line while enabled.
    always_comb begin
        w_rise     = i_irq & ~r_irq_prev;
        w_clr      = (w_wr_pend ? w_wdata_n : '0) | (w_ack_take ? w_active_oh : '0);
        w_pend_nxt = (r_edge & ((r_pending & ~w_clr) | w_rise))
                   | (~r_edge & i_irq & r_enable);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_active <= '0;
            r_vector <= VECTOR_BASE;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            r_vector <= w_vector_nxt;
        end
    end

    // irq_prev resets high so a line already asserted is not seen as an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending  <= '0;
            r_enable   <= '0;
            r_edge     <= '0;
            r_irq_prev <= '1;
        end else if (i_ce) begin
            r_pending  <= w_pend_nxt;
            r_irq_prev <= i_irq;
            if (w_wr_en) begin
                r_enable <= w_wdata_n;
            end
            if (w_wr_edge) begin
                r_edge <= w_wdata_n;
            end
        end
    end

    assign o_int    = (r_state == ST_REQ);
    assign o_vector = r_vector;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_ctrl
//  Purpose  : Directed table-driven self-checking bench for int_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

    localparam logic [15:0] A_PEND = 16'hFF00;
    localparam logic [15:0] A_EN   = 16'hFF01;
    localparam logic [15:0] A_EDGE = 16'hFF02;
    localparam logic [15:0] A_STAT = 16'hFF03;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [7:0]  irq;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] rdata;
    logic        intr;
    logic [15:0] vector;
    logic        ack;
    logic        eoi;

    int n_checks;
    int n_errors;

    int_ctrl dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_ce     (ce),
        .i_irq    (irq),
        .i_addr   (addr),
        .i_wdata  (wdata),
        .i_we     (we),
        .o_rdata  (rdata),
        .o_int    (intr),
        .o_vector (vector),
        .i_ack    (ack),
        .i_eoi    (eoi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [7:0]  irq;
        logic        ack;
        logic        eoi;
        logic [15:0] raddr;
        logic        exp_int;
        logic [15:0] exp_vec;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic w, input logic [15:0] a, input logic [15:0] d,
                                input logic [7:0] q, input logic k, input logic e,
                                input logic [15:0] ra, input logic ei,
                                input logic [15:0] ev, input logic [15:0] er);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.irq = q; v.ack = k; v.eoi = e;
        v.raddr = ra; v.exp_int = ei; v.exp_vec = ev; v.exp_rdata = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock edge with the given inputs, then read back at raddr.
    task automatic cyc(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [7:0] q, input logic k, input logic e,
                       input logic [15:0] ra);
        we = w; addr = w ? a : ra; wdata = d; irq = q; ack = k; eoi = e;
        @(posedge clk);
        #1;
        we = 1'b0; ack = 1'b0; eoi = 1'b0; addr = ra;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; ce = 1'b1; irq = '0; addr = A_PEND; wdata = '0;
        we = 1'b0; ack = 1'b0; eoi = 1'b0;

        //           we addr    wdata    irq    ack eoi raddr   int vec       rdata
        tbl.push_back(mk(1, A_EN,   16'h00FF, 8'h00, 0, 0, A_EN,   0, 16'h2002, 16'h00FF));
        tbl.push_back(mk(1, A_EDGE, 16'h00FF, 8'h00, 0, 0, A_EDGE, 0, 16'h2002, 16'h00FF));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h08, 0, 0, A_PEND, 0, 16'h2002, 16'h0008));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 0, 0, A_PEND, 1, 16'h2008, 16'h0008));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 1, 0, A_STAT, 0, 16'h2008, 16'h8003));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 0, 0, A_PEND, 0, 16'h2008, 16'h0000));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 0, 1, A_STAT, 0, 16'h2008, 16'h0000));
        // two simultaneous edges: channel 2 before channel 5
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h24, 0, 0, A_PEND, 0, 16'h2008, 16'h0024));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 0, 0, A_STAT, 1, 16'h2006, 16'h0002));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 1, 0, A_PEND, 0, 16'h2006, 16'h0020));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 0, 1, A_STAT, 0, 16'h2006, 16'h0000));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 0, 0, A_STAT, 1, 16'h200C, 16'h0005));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 1, 1, A_STAT, 0, 16'h200C, 16'h8005));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 0, 1, A_STAT, 0, 16'h200C, 16'h0000));
        // channel 1 in level mode, line held through ack/eoi
        tbl.push_back(mk(1, A_EDGE, 16'h00FD, 8'h00, 0, 0, A_EDGE, 0, 16'h200C, 16'h00FD));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h02, 0, 0, A_PEND, 0, 16'h200C, 16'h0002));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h02, 0, 0, A_STAT, 1, 16'h2004, 16'h0001));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h02, 1, 0, A_PEND, 0, 16'h2004, 16'h0002));
        tbl.push_back(mk(1, A_PEND, 16'h0002, 8'h02, 0, 0, A_PEND, 0, 16'h2004, 16'h0002));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h02, 0, 1, A_STAT, 0, 16'h2004, 16'h0000));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h02, 0, 0, A_STAT, 1, 16'h2004, 16'h0001));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h02, 1, 0, A_STAT, 0, 16'h2004, 16'h8001));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 0, 1, A_PEND, 0, 16'h2004, 16'h0000));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 0, 1, A_PEND, 0, 16'h2004, 16'h0000));
        // channel 4 request stays committed after ENABLE is cleared
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h10, 0, 0, A_PEND, 0, 16'h2004, 16'h0010));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 0, 0, A_STAT, 1, 16'h200A, 16'h0004));
        tbl.push_back(mk(1, A_EN,   16'h0000, 8'h00, 0, 0, A_EN,   1, 16'h200A, 16'h0000));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 0, 0, A_STAT, 1, 16'h200A, 16'h0004));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 1, 0, A_PEND, 0, 16'h200A, 16'h0000));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 0, 1, A_STAT, 0, 16'h200A, 16'h0000));
        // W1C versus simultaneous edge, stray ack, address decode limits
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h01, 0, 0, A_PEND, 0, 16'h200A, 16'h0001));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 0, 0, 16'hFF04, 0, 16'h200A, 16'h0000));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 1, 0, A_PEND, 0, 16'h200A, 16'h0001));
        tbl.push_back(mk(1, A_PEND, 16'h0001, 8'h01, 0, 0, A_PEND, 0, 16'h200A, 16'h0001));
        tbl.push_back(mk(1, A_PEND, 16'h0001, 8'h01, 0, 0, A_PEND, 0, 16'h200A, 16'h0000));
        tbl.push_back(mk(0, A_PEND, 16'h0000, 8'h00, 0, 0, A_PEND, 0, 16'h200A, 16'h0000));
        tbl.push_back(mk(1, 16'hFF05, 16'hFFFF, 8'h00, 0, 0, A_EN, 0, 16'h200A, 16'h0000));
        tbl.push_back(mk(1, A_EN,   16'hFFFF, 8'h00, 0, 0, A_EN,   0, 16'h200A, 16'h00FF));
        tbl.push_back(mk(1, A_EN,   16'h0000, 8'h00, 0, 0, A_EN,   0, 16'h200A, 16'h0000));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset int", 16'(intr), 16'h0000);
        chk("reset vector", vector, 16'h2002);
        addr = A_PEND; #1; chk("reset PENDING", rdata, 16'h0000);
        addr = A_EN;   #1; chk("reset ENABLE", rdata, 16'h0000);
        addr = A_STAT; #1; chk("reset STATUS", rdata, 16'h0000);
        rst = 1'b0;

        foreach (tbl[i]) begin
            cyc(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].irq, tbl[i].ack, tbl[i].eoi,
                tbl[i].raddr);
            chk($sformatf("step%0d int", i), 16'(intr), 16'(tbl[i].exp_int));
            chk($sformatf("step%0d vector", i), vector, tbl[i].exp_vec);
            chk($sformatf("step%0d rdata", i), rdata, tbl[i].exp_rdata);
        end

        // Clock enable low: writes and edges are ignored
        ce = 1'b0;
        cyc(1, A_EN, 16'h0055, 8'h01, 0, 0, A_EN);
        cyc(1, A_EN, 16'h0055, 8'h01, 0, 0, A_EN);
        cyc(0, A_EN, 16'h0000, 8'h00, 0, 0, A_EN);
        ce = 1'b1;
        cyc(0, A_EN, 16'h0000, 8'h00, 0, 0, A_EN);
        chk("ce=0 ENABLE", rdata, 16'h0000);
        addr = A_PEND; #1;
        chk("ce=0 PENDING", rdata, 16'h0000);

        // Reset while in service
        cyc(1, A_EN, 16'h0001, 8'h00, 0, 0, A_STAT);
        cyc(0, A_EN, 16'h0000, 8'h01, 0, 0, A_STAT);
        irq = 8'h00;
        begin
            int budget;
            budget = 0;
            while (!intr && budget < 5) begin
                cyc(0, A_EN, 16'h0000, 8'h00, 0, 0, A_STAT);
                budget++;
            end
            chk("svc wait int", 16'(intr), 16'h0001);
        end
        chk("svc vector", vector, 16'h2002);
        cyc(0, A_EN, 16'h0000, 8'h00, 1, 0, A_STAT);
        chk("svc STATUS", rdata, 16'h8000);
        chk("svc int", 16'(intr), 16'h0000);
        rst = 1'b1;
        cyc(0, A_EN, 16'h0000, 8'h00, 0, 0, A_STAT);
        chk("rst-in-svc STATUS", rdata, 16'h0000);
        chk("rst-in-svc int", 16'(intr), 16'h0000);
        chk("rst-in-svc vector", vector, 16'h2002);
        addr = A_EN; #1;
        chk("rst-in-svc ENABLE", rdata, 16'h0000);

        // Lines held high through reset must not create edges
        irq = 8'hFF;
        cyc(0, A_EN, 16'h0000, 8'hFF, 0, 0, A_PEND);
        rst = 1'b0;
        cyc(1, A_EDGE, 16'h00FF, 8'hFF, 0, 0, A_PEND);
        cyc(1, A_EN,   16'h00FF, 8'hFF, 0, 0, A_PEND);
        repeat (3) cyc(0, A_EN, 16'h0000, 8'hFF, 0, 0, A_PEND);
        chk("held-irq PENDING", rdata, 16'h0000);
        chk("held-irq int", 16'(intr), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
